// File: rtl/lsu_mem_port_pkg.sv
// Package for the MEM-stage load/store port.
// Holds the funct3 / load-type / store-type encodings, exception cause codes,
// FSM state encoding and the access-check result type shared by the LSU files.
package lsu_mem_port_pkg;

    // funct3 encodings. Memory load/store types reuse the same values.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Load type presented to memory on cycles that do not issue a load.
    localparam logic [2:0] LT_NONE = 3'b111;

    // mcause-style exception codes.
    localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LD_WAIT  = 2'd1,
        ST_RSP_HOLD = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic       fault;
        logic [3:0] cause;
    } access_chk_t;

    // Access size is carried in funct3[1:0]: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Interface bundling the LSU request, WB response, exception and data memory
// signals of lsu_mem_port.
//   slave  : the LSU itself (takes requests, drives response/exception/memory)
//   master : the surrounding pipeline and data memory
interface lsu_mem_port_if;
    // Request from the pipeline
    logic        req_valid;
    logic        req_ready;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    // Load response to WB
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    // Exception report
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;
    // Data memory port
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_load_type;
    logic [2:0]  mem_store_type;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_rd,
        input  rsp_ready,
        output exc_valid, exc_cause, exc_addr,
        output mem_we, mem_addr, mem_wdata, mem_load_type, mem_store_type,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_rd,
        output rsp_ready,
        input  exc_valid, exc_cause, exc_addr,
        input  mem_we, mem_addr, mem_wdata, mem_load_type, mem_store_type,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_port_access_check.sv
// Combinational legality / alignment check for one load or store request.
// Ports:
//   is_load, is_store : operation kind (neither = no-op, never faults)
//   funct3            : RV funct3 of the access
//   addr_lo           : low two bits of the effective address
//   chk               : fault flag plus cause code (illegal funct3 wins over
//                       misalignment, since an illegal funct3 has no size)
module lsu_mem_port_access_check
    import lsu_mem_port_pkg::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output access_chk_t chk
);

    logic f3_legal;
    logic misaligned;

    always_comb begin
        f3_legal = 1'b1;
        if (is_load) begin
            f3_legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end else if (is_store) begin
            f3_legal = funct3 inside {F3_B, F3_H, F3_W};
        end

        misaligned = (is_load | is_store) & f3_legal & is_misaligned(funct3, addr_lo);

        chk.fault = ~f3_legal | misaligned;
        if (!f3_legal) begin
            chk.cause = CAUSE_ILLEGAL;
        end else if (is_load) begin
            chk.cause = CAUSE_LD_MISALIGN;
        end else begin
            chk.cause = CAUSE_ST_MISALIGN;
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// MEM-stage load/store initiator for the RV32IM pipeline.
// Accepts one request per valid/ready handshake, rejects illegal or misaligned
// accesses with a one-cycle exception pulse, issues stores in the accept cycle
// (one per cycle) and loads with a response to WB the cycle after accept.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   flush  : kills a pending load response and blocks acceptance
//   bus    : request / response / exception / data memory bundle (slave side)
//   ld_cnt : completed aligned loads (wraps)
//   st_cnt : issued aligned stores (wraps)
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    lsu_mem_port_if.slave    bus,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    lsu_state_e       state_reg;
    logic [31:0]      hold_rdata_reg;
    logic [4:0]       rsp_rd_reg;
    logic             exc_valid_reg;
    logic [3:0]       exc_cause_reg;
    logic [31:0]      exc_addr_reg;
    logic [CNT_W-1:0] ld_cnt_reg;
    logic [CNT_W-1:0] st_cnt_reg;

    access_chk_t chk;
    logic        req_ready_w;
    logic        accept;
    logic        issue_load;
    logic        issue_store;
    logic        exc_fire;

    lsu_mem_port_access_check u_check (
        .is_load  (bus.req_is_load),
        .is_store (bus.req_is_store),
        .funct3   (bus.req_funct3),
        .addr_lo  (bus.req_addr[1:0]),
        .chk      (chk)
    );

    always_comb begin
        req_ready_w = (state_reg == ST_IDLE) & ~flush;
        accept      = bus.req_valid & req_ready_w;
        issue_load  = accept & bus.req_is_load & ~chk.fault;
        // Load takes precedence should both kind bits ever be set.
        issue_store = accept & bus.req_is_store & ~bus.req_is_load & ~chk.fault;
        exc_fire    = accept & chk.fault;
    end

    // Memory side: stores and load types go out in the accept cycle itself;
    // address and data simply follow the request inputs.
    assign bus.req_ready      = req_ready_w;
    assign bus.mem_we         = issue_store;
    assign bus.mem_addr       = bus.req_addr;
    assign bus.mem_wdata      = bus.req_wdata;
    assign bus.mem_store_type = bus.req_funct3;
    assign bus.mem_load_type  = issue_load ? bus.req_funct3 : LT_NONE;

    // In LD_WAIT the memory's registered data is forwarded live; afterwards the
    // memory re-registers every cycle, so a stalled response comes from the
    // hold register captured on the LD_WAIT edge.
    assign bus.rsp_valid = (state_reg != ST_IDLE) & ~flush;
    assign bus.rsp_rdata = (state_reg == ST_LD_WAIT) ? bus.mem_rdata : hold_rdata_reg;
    assign bus.rsp_rd    = rsp_rd_reg;

    assign bus.exc_valid = exc_valid_reg;
    assign bus.exc_cause = exc_cause_reg;
    assign bus.exc_addr  = exc_addr_reg;

    assign ld_cnt = ld_cnt_reg;
    assign st_cnt = st_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            hold_rdata_reg <= '0;
            rsp_rd_reg     <= '0;
            exc_valid_reg  <= 1'b0;
            exc_cause_reg  <= '0;
            exc_addr_reg   <= '0;
            ld_cnt_reg     <= '0;
            st_cnt_reg     <= '0;
        end else begin
            exc_valid_reg <= exc_fire;
            if (exc_fire) begin
                exc_cause_reg <= chk.cause;
                exc_addr_reg  <= bus.req_addr;
            end

            if (issue_store) begin
                st_cnt_reg <= st_cnt_reg + CNT_W'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (issue_load) begin
                        rsp_rd_reg <= bus.req_rd;
                        state_reg  <= ST_LD_WAIT;
                    end
                end
                ST_LD_WAIT: begin
                    // flush beats rsp_ready: the response is dropped uncounted.
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else if (bus.rsp_ready) begin
                        state_reg  <= ST_IDLE;
                        ld_cnt_reg <= ld_cnt_reg + CNT_W'(1);
                    end else begin
                        hold_rdata_reg <= bus.mem_rdata;
                        state_reg      <= ST_RSP_HOLD;
                    end
                end
                ST_RSP_HOLD: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                    end else if (bus.rsp_ready) begin
                        state_reg  <= ST_IDLE;
                        ld_cnt_reg <= ld_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
